// File: rtl/shift_rows_stream.sv
// shift_rows_stream: byte-serial forward AES ShiftRows engine.
// Bytes arrive column-major, 16 per block, into a two-bank ping-pong store.
// The draining bank is read through the ShiftRows index map, so one bank
// fills while the other empties and full throughput is sustained.
module shift_rows_stream (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last
);

   localparam int DATA_W = 8;
   localparam int BLK_N  = 16;

   // Byte storage: bank contents are never reset, only the control state.
   logic [DATA_W-1:0] bank [0:1][0:BLK_N-1];

   logic [1:0] full;
   logic [1:0] full_nxt;
   logic       wb;
   logic       rb;
   logic [3:0] wcnt;
   logic [3:0] rcnt;
   logic       wr_fire;
   logic       rd_fire;
   logic       wr_done;
   logic       rd_done;

   // Output position j sits at row j%4, column j/4; row r is rotated left
   // by r columns, so the source column is (c + r) mod 4 on the same row.
   function automatic logic [3:0] src_idx(input logic [3:0] j);
      logic [1:0] row;
      logic [1:0] col;
      row = j[1:0];
      col = j[3:2] + j[1:0];
      return {col, row};
   endfunction

   assign in_ready  = !full[wb];
   assign out_valid = full[rb];
   assign out_last  = out_valid && (rcnt == 4'd15);
   assign out_data  = out_valid ? bank[rb][src_idx(rcnt)] : '0;

   assign wr_fire = in_valid && in_ready;
   assign rd_fire = out_valid && out_ready;
   assign wr_done = wr_fire && (wcnt == 4'd15);
   assign rd_done = rd_fire && (rcnt == 4'd15);

   // Full flags: a completed write marks its bank full, a completed read
   // frees its bank. Both can only coincide on different banks, because a
   // full bank never accepts writes.
   always_comb begin
      full_nxt = full;
      if (wr_done) full_nxt[wb] = 1'b1;
      if (rd_done) full_nxt[rb] = 1'b0;
   end

   // Write side: store the accepted byte at its arrival position.
   always_ff @(posedge clk) begin
      if (wr_fire) bank[wb][wcnt] <= in_data;
   end

   // Control state: counters, bank pointers and full flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb   <= 1'b0;
         rb   <= 1'b0;
         wcnt <= 4'd0;
         rcnt <= 4'd0;
         full <= 2'b00;
      end else begin
         if (wr_fire) begin
            wcnt <= wcnt + 4'd1;
            if (wr_done) wb <= ~wb;
         end
         if (rd_fire) begin
            rcnt <= rcnt + 4'd1;
            if (rd_done) rb <= ~rb;
         end
         full <= full_nxt;
      end
   end

endmodule
